// File: rtl/ifetch_mem_port_pkg.sv
// Shared width/constant macros and helpers for the instruction-fetch memory port.
// Compile this file first so the macros are visible to every later file.
`ifndef IFETCH_MEM_PORT_DEFINES
`define IFETCH_MEM_PORT_DEFINES
`define ADDR_TYPE 31:0
`define INS_TYPE  31:0
`define BYTE_TYPE 7:0
`define ZERO_WORD 32'h0000_0000
`define ZERO_ADDR 32'h0000_0000
`define TRUE      1'b1
`define FALSE     1'b0
`endif

package ifetch_mem_port_pkg;

   localparam logic [2:0] STEP_IDLE  = 3'd0;
   localparam logic [2:0] STEP_FIRST = 3'd1;
   localparam logic [2:0] STEP_LAST  = 3'd5;

   // Little-endian placement: byte lane idx occupies bits [8*idx+7 : 8*idx].
   function automatic logic [31:0] insertByte(input logic [31:0] word,
                                              input logic [1:0]  idx,
                                              input logic [7:0]  b);
      logic [31:0] result;
      result = word;
      case (idx)
         2'd0:    result[7:0]   = b;
         2'd1:    result[15:8]  = b;
         2'd2:    result[23:16] = b;
         default: result[31:24] = b;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/ifetch_mem_port.sv
// Byte-serial instruction fetch port: reads four bytes from a one-cycle-latency
// RAM, assembles a little-endian word and pulses ok for one cycle.
import ifetch_mem_port_pkg::*;

module ifetch_mem_port (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic [`ADDR_TYPE] pc_from_if,
   input  logic              ena_from_if,
   input  logic              drop_flag_from_if,
   input  logic [`BYTE_TYPE] mem_din,
   output logic [`ADDR_TYPE] mem_a,
   output logic              mem_wr,
   output logic              ok_flag_to_if,
   output logic [`INS_TYPE]  inst_to_if
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        step_q, step_d;
   logic [`ADDR_TYPE] pc_q, pc_d;
   logic [`ADDR_TYPE] addr_q, addr_d;
   logic [`INS_TYPE]  data_q, data_d;
   logic [`INS_TYPE]  inst_q, inst_d;
   logic              ok_q, ok_d;
   logic [1:0]        byteIdx;

   // Step k>=2 captures the byte whose address went out two steps earlier.
   assign byteIdx = 2'(step_q - 3'd2);

   // Abort has top priority, then the rdy freeze; ok is only ever a single pulse.
   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      pc_d    = pc_q;
      addr_d  = addr_q;
      data_d  = data_q;
      inst_d  = inst_q;
      ok_d    = `FALSE;
      if (drop_flag_from_if) begin
         state_d = IDLE;
         step_d  = STEP_IDLE;
         addr_d  = `ZERO_ADDR;
         data_d  = `ZERO_WORD;
      end else if (rdy) begin
         case (state_q)
            IDLE: begin
               if (ena_from_if) begin
                  state_d = BUSY;
                  step_d  = STEP_FIRST;
                  pc_d    = pc_from_if;
                  addr_d  = pc_from_if;
                  data_d  = `ZERO_WORD;
               end
            end
            default: begin
               if (step_q >= 3'd2) begin
                  data_d = insertByte(data_q, byteIdx, mem_din);
               end
               if (step_q <= 3'd3) begin
                  addr_d = pc_q + {29'd0, step_q};
               end
               if (step_q == STEP_LAST) begin
                  ok_d    = `TRUE;
                  inst_d  = insertByte(data_q, byteIdx, mem_din);
                  state_d = IDLE;
                  step_d  = STEP_IDLE;
                  addr_d  = `ZERO_ADDR;
                  data_d  = `ZERO_WORD;
               end else begin
                  step_d = step_q + 3'd1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         step_q  <= STEP_IDLE;
         pc_q    <= `ZERO_ADDR;
         addr_q  <= `ZERO_ADDR;
         data_q  <= `ZERO_WORD;
         inst_q  <= `ZERO_WORD;
         ok_q    <= `FALSE;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         inst_q  <= inst_d;
         ok_q    <= ok_d;
      end
   end

   assign mem_a         = addr_q;
   assign mem_wr        = `FALSE;
   assign ok_flag_to_if = ok_q;
   assign inst_to_if    = inst_q;

endmodule

// File: doc/ifetch_mem_port.md
IFETCH_MEM_PORT -- requirements
Module: ifetch_mem_port

Interface
REQ-001 SHALL have these ports, clock and reset first:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- rdy  input  1  global ready; low freezes all state.
- pc_from_if  input  32  fetch address, sampled with the request.
- ena_from_if  input  1  one-cycle request pulse from the fetcher.
- drop_flag_from_if  input  1  one-cycle abort pulse (rollback).
- mem_din  input  8  RAM read byte.
- mem_a  output  32  RAM byte address.
- mem_wr  output  1  RAM write enable.
- ok_flag_to_if  output  1  one-cycle completion pulse.
- inst_to_if  output  32  assembled instruction, valid while ok_flag_to_if is high.

Function
REQ-002 SHALL implement states IDLE and BUSY, plus a 3-bit step counter (0..5).
REQ-003 In IDLE with ena_from_if=1 at an edge, SHALL do all of the following at that edge:
- latch pc_from_if;
- drive mem_a=pc_from_if;
- set step=1;
- enter BUSY.
REQ-004 In BUSY, step=k (1..3) at an edge SHALL drive mem_a=latched_pc+k, wrapping mod 2^32, then step=k+1.
REQ-005 RAM read latency is one cycle: the byte for the address driven after edge Ek SHALL be sampled from mem_din at edge Ek+2.
REQ-006 Byte i (address pc+i) SHALL be written to inst bits [8i+7:8i] (little-endian) at edge E(i+2), i=0..3.
REQ-007 At edge E5, after capturing byte 3, the block SHALL:
- drive ok_flag_to_if=1 and inst_to_if=assembled word for exactly one cycle;
- return to IDLE.
REQ-008 Request-to-ok latency is therefore fixed at 5 cycles with rdy continuously high.
REQ-009 ok_flag_to_if SHALL be 0 in every cycle other than the completion cycle.
REQ-010 inst_to_if SHALL hold its last value when ok_flag_to_if=0.
REQ-011 mem_wr SHALL be constant 0; this block never writes.
REQ-012 In IDLE with no request, mem_a SHALL be 0.
REQ-013 drop_flag_from_if=1 at any edge SHALL:
- abort the transaction and force IDLE with step=0 and mem_a=0;
- suppress ok_flag_to_if, including at the E5 edge;
- discard partial data.
REQ-014 drop_flag_from_if and ena_from_if both high at one edge SHALL resolve to drop winning; the request is ignored.
REQ-015 ena_from_if while BUSY SHALL be ignored, with no queueing.
REQ-016 rdy=0 at an edge SHALL freeze state, step, latched pc, partial data and mem_a, and SHALL force ok_flag_to_if=0.
REQ-017 A completion that is frozen by rdy=0 SHALL fire on the first edge with rdy=1.
REQ-018 Bytes sampled are re-timed to account for rdy stalls: the counter advances only on rdy=1 edges, and the RAM is stalled by the same rdy.
REQ-019 A new request accepted in the cycle right after ok_flag_to_if (IDLE) SHALL start normally; back-to-back throughput is one word per 6 cycles.

Reset
REQ-020 rst=1 SHALL asynchronously force all of: state=IDLE, step=0, latched pc=0, partial data=0, mem_a=0, mem_wr=0, ok_flag_to_if=0, inst_to_if=0.
REQ-021 rst SHALL override rdy, drop and ena.
REQ-022 Reset asserted mid-transaction SHALL discard the transaction, with no ok pulse after deassertion.
REQ-023 The first request SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-024 Address/instruction width macros (ADDR_TYPE, INS_TYPE), ZERO_WORD, ZERO_ADDR, TRUE/FALSE and a new BYTE_TYPE (7:0) SHALL come from the shared defines file.
REQ-025 State encodings SHALL be local parameters of this module.
REQ-026 No sub-module SHALL be used; a single sequential process plus output assigns is sufficient.

Verification
REQ-027 The bench SHALL cover these scenarios:
- Single fetch: RAM[0x100..0x103]=13,05,A0,00; ena pulse with pc=0x100. Response: mem_a sequence 0x100,0x101,0x102,0x103; ok pulse 5 cycles later with inst=0x00A00513.
- Wrap: pc=0xFFFFFFFE. Response: mem_a sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001; inst built from those bytes.
- Drop mid-fetch: drop at step 3. Response: no ok pulse, mem_a=0 next cycle; a new request with pc=0x200 then completes with correct data.
- Simultaneous drop+ena in IDLE, and drop coinciding with E5. Response: no acceptance and no ok pulse respectively.
- rdy low for 3 cycles at step 2. Response: mem_a and step held; ok arrives 8 cycles after request with correct inst.
- Async reset pulse between edges during BUSY. Response: outputs zero immediately, no later ok; the next request after release returns correct data.
